// File: rtl/vga_fb_writer_pkg.sv
// Shared types and sizing helpers for the frame-buffer writer.
// Holds the FSM encoding, clog2 and default geometry constants.
package vga_fb_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PEND  = 2'd2
  } fb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  localparam int H_WIDTH_DEF    = 640;
  localparam int V_WIDTH_DEF    = 480;
  localparam int DECIM_DEF      = 1;
  localparam int PXL_WIDTH_DEF  = 12;
  localparam int LINE_PIX_DEF   = H_WIDTH_DEF / DECIM_DEF;
  localparam int FRAME_PIX_DEF  = LINE_PIX_DEF * (V_WIDTH_DEF / DECIM_DEF);
  localparam int ADDR_WIDTH_DEF = clog2(FRAME_PIX_DEF) + 1;

endpackage

// File: rtl/vga_fb_writer_addr_gen.sv
// fb_addr_gen: pixel qualification plus 2-stage coordinate-to-linear
// address pipeline. Ports: raw pixel in, comb accept/first/last out,
// stage-2 linear address and pixel data out.
module fb_addr_gen
  import vga_fb_writer_pkg::*;
#(
  parameter int H_WIDTH   = H_WIDTH_DEF,
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int DECIM     = DECIM_DEF,
  parameter int PXL_WIDTH = PXL_WIDTH_DEF,
  parameter int LIN_W     = ADDR_WIDTH_DEF - 1
) (
  input  logic                 i_clk,
  input  logic                 i_n_reset,
  input  logic [9:0]           i_h_addr,
  input  logic [9:0]           i_v_addr,
  input  logic                 i_valid,
  input  logic [3:0]           i_pxl_r,
  input  logic [3:0]           i_pxl_g,
  input  logic [3:0]           i_pxl_b,
  output logic                 o_acc,
  output logic                 o_first,
  output logic                 o_last,
  output logic [LIN_W-1:0]     o_lin_addr,
  output logic [PXL_WIDTH-1:0] o_data
);

  localparam int SHIFT = (DECIM == 2) ? 1 : 0;
  localparam int LINE  = H_WIDTH / DECIM;

  logic                 in_range;
  logic                 on_grid;
  logic                 acc_s1;
  logic [9:0]           h_s1;
  logic [9:0]           v_s1;
  logic [PXL_WIDTH-1:0] data_s1;

  assign in_range = (i_h_addr < 10'(H_WIDTH))
                 && (i_v_addr < 10'(V_WIDTH));

  // With 2:1 decimation only even rows and columns are kept.
  assign on_grid = (DECIM == 1)
                || (!i_h_addr[0] && !i_v_addr[0]);

  assign o_acc   = i_valid && in_range && on_grid;
  assign o_first = (i_h_addr == 10'd0) && (i_v_addr == 10'd0);
  assign o_last  = (i_h_addr == 10'(H_WIDTH - DECIM))
                && (i_v_addr == 10'(V_WIDTH - DECIM));

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      acc_s1  <= 1'b0;
      h_s1    <= '0;
      v_s1    <= '0;
      data_s1 <= '0;
    end else begin
      acc_s1 <= o_acc;
      if (o_acc) begin
        h_s1    <= i_h_addr >> SHIFT;
        v_s1    <= i_v_addr >> SHIFT;
        data_s1 <= PXL_WIDTH'({i_pxl_r, i_pxl_g, i_pxl_b});
      end
    end
  end

  // Address/data hold the last accepted pixel between writes.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      o_lin_addr <= '0;
      o_data     <= '0;
    end else if (acc_s1) begin
      o_lin_addr <= LIN_W'(32'(v_s1) * 32'(LINE) + 32'(h_s1));
      o_data     <= data_s1;
    end
  end

endmodule

// File: rtl/vga_fb_writer.sv
// Ping-pong frame-buffer write controller: pixels in, BRAM writes out,
// bank ownership handed to the VGA reader on its frame-start pulse.
module vga_fb_writer
  import vga_fb_writer_pkg::*;
#(
  parameter int H_WIDTH    = H_WIDTH_DEF,
  parameter int V_WIDTH    = V_WIDTH_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int PXL_WIDTH  = PXL_WIDTH_DEF,
  parameter int ADDR_WIDTH =
    clog2((H_WIDTH / DECIM) * (V_WIDTH / DECIM)) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic [9:0]            i_h_addr,
  input  logic [9:0]            i_v_addr,
  input  logic                  i_valid,
  input  logic [3:0]            i_pxl_r,
  input  logic [3:0]            i_pxl_g,
  input  logic [3:0]            i_pxl_b,
  input  logic                  i_rd_vsync,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [PXL_WIDTH-1:0]  o_wr_data,
  output logic                  o_rd_bank,
  output logic                  o_frame_done,
  output logic [7:0]            o_drop_cnt
);

  localparam int LIN_W = ADDR_WIDTH - 1;

  fb_state_t            state_q;
  fb_state_t            state_d;
  logic                 acc;
  logic                 first;
  logic                 last;
  logic                 wr_go;
  logic                 done_go;
  logic                 drop_go;
  logic                 swap_go;
  logic                 wr_bank_q;
  logic                 rd_bank_q;
  logic                 go_s1;
  logic                 done_s1;
  logic                 bank_s1;
  logic                 bank_q;
  logic [7:0]           drop_q;
  logic [LIN_W-1:0]     lin_addr;
  logic [PXL_WIDTH-1:0] pix_data;

  fb_addr_gen #(
    .H_WIDTH   (H_WIDTH),
    .V_WIDTH   (V_WIDTH),
    .DECIM     (DECIM),
    .PXL_WIDTH (PXL_WIDTH),
    .LIN_W     (LIN_W)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_n_reset  (i_n_reset),
    .i_h_addr   (i_h_addr),
    .i_v_addr   (i_v_addr),
    .i_valid    (i_valid),
    .i_pxl_r    (i_pxl_r),
    .i_pxl_g    (i_pxl_g),
    .i_pxl_b    (i_pxl_b),
    .o_acc      (acc),
    .o_first    (first),
    .o_last     (last),
    .o_lin_addr (lin_addr),
    .o_data     (pix_data)
  );

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc && first) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (acc && last) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (i_rd_vsync)
          state_d = (acc && first) ? ST_WRITE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decisions are taken on the raw pixel so that a vsync and a
  // first pixel arriving together are seen in the same cycle.
  always_comb begin
    wr_go   = 1'b0;
    done_go = 1'b0;
    drop_go = 1'b0;
    swap_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_go = acc && first;
      end
      ST_WRITE: begin
        wr_go   = acc;
        done_go = acc && last;
        drop_go = acc && first && !last;
      end
      ST_PEND: begin
        swap_go = i_rd_vsync;
        wr_go   = i_rd_vsync && acc && first;
        drop_go = !i_rd_vsync && acc && first;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
    end else if (swap_go) begin
      rd_bank_q <= wr_bank_q;
      wr_bank_q <= ~wr_bank_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset)
      drop_q <= 8'd0;
    else if (drop_go && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  // Control travels alongside the address pipeline; the bank is
  // captured per pixel so a write after a swap lands in the new bank.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      go_s1        <= 1'b0;
      done_s1      <= 1'b0;
      bank_s1      <= 1'b0;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      bank_q       <= 1'b0;
    end else begin
      go_s1        <= wr_go;
      done_s1      <= done_go;
      bank_s1      <= swap_go ? ~wr_bank_q : wr_bank_q;
      o_wr_en      <= go_s1;
      o_frame_done <= done_s1;
      if (go_s1) bank_q <= bank_s1;
    end
  end

  assign o_wr_addr  = {bank_q, lin_addr};
  assign o_wr_data  = pix_data;
  assign o_rd_bank  = rd_bank_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: small-geometry instances for
// full-frame flows plus a default-geometry instance for address range.
module tb_vga_fb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] h;
  logic [9:0] v;
  logic [3:0] pr;
  logic [3:0] pg;
  logic [3:0] pb;
  logic       vld1, vld2, vld3;
  logic       vs1, vs2, vs3;

  logic        wen1, done1, rdb1;
  logic [7:0]  wadr1;
  logic [11:0] wdat1;
  logic [7:0]  drop1;

  logic        wen2, done2, rdb2;
  logic [5:0]  wadr2;
  logic [11:0] wdat2;
  logic [7:0]  drop2;

  logic        wen3, done3, rdb3;
  logic [19:0] wadr3;
  logic [11:0] wdat3;
  logic [7:0]  drop3;

  vga_fb_writer #(.H_WIDTH(16), .V_WIDTH(8), .DECIM(1)) dut1 (
    .i_clk(clk), .i_n_reset(rst_n), .i_h_addr(h), .i_v_addr(v),
    .i_valid(vld1), .i_pxl_r(pr), .i_pxl_g(pg), .i_pxl_b(pb),
    .i_rd_vsync(vs1), .o_wr_en(wen1), .o_wr_addr(wadr1),
    .o_wr_data(wdat1), .o_rd_bank(rdb1), .o_frame_done(done1),
    .o_drop_cnt(drop1)
  );

  vga_fb_writer #(.H_WIDTH(16), .V_WIDTH(8), .DECIM(2)) dut2 (
    .i_clk(clk), .i_n_reset(rst_n), .i_h_addr(h), .i_v_addr(v),
    .i_valid(vld2), .i_pxl_r(pr), .i_pxl_g(pg), .i_pxl_b(pb),
    .i_rd_vsync(vs2), .o_wr_en(wen2), .o_wr_addr(wadr2),
    .o_wr_data(wdat2), .o_rd_bank(rdb2), .o_frame_done(done2),
    .o_drop_cnt(drop2)
  );

  vga_fb_writer dut3 (
    .i_clk(clk), .i_n_reset(rst_n), .i_h_addr(h), .i_v_addr(v),
    .i_valid(vld3), .i_pxl_r(pr), .i_pxl_g(pg), .i_pxl_b(pb),
    .i_rd_vsync(vs3), .o_wr_en(wen3), .o_wr_addr(wadr3),
    .o_wr_data(wdat3), .o_rd_bank(rdb3), .o_frame_done(done3),
    .o_drop_cnt(drop3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          wcnt1 = 0, dcnt1 = 0, wcnt2 = 0, dcnt2 = 0;
  logic [7:0]  dadr1;
  logic [11:0] ddat1;
  logic        dwr1;
  logic [5:0]  dadr2;
  logic [11:0] ddat2;
  logic        dwr2;

  always @(negedge clk) begin
    if (wen1) wcnt1++;
    if (done1) begin
      dcnt1++;
      dadr1 = wadr1;
      ddat1 = wdat1;
      dwr1  = wen1;
    end
    if (wen2) wcnt2++;
    if (done2) begin
      dcnt2++;
      dadr2 = wadr2;
      ddat2 = wdat2;
      dwr2  = wen2;
    end
  end

  task automatic pix(input int sel, input int hh,
                     input int vv, input logic vs);
    h    = 10'(hh);
    v    = 10'(vv);
    pr   = 4'(hh);
    pg   = 4'(vv);
    pb   = 4'd0;
    vld1 = (sel == 1);
    vld2 = (sel == 2);
    vld3 = (sel == 3);
    vs1  = vs && (sel == 1);
    vs2  = vs && (sel == 2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    vld1 = 0; vld2 = 0; vld3 = 0;
    vs1  = 0; vs2  = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync(input int sel);
    vld1 = 0; vld2 = 0; vld3 = 0;
    vs1  = (sel == 1);
    vs2  = (sel == 2);
    @(negedge clk);
    vs1 = 0;
    vs2 = 0;
  endtask

  task automatic frame(input int sel, input int from, input int upto);
    for (int i = from; i < upto; i++) pix(sel, i % 16, i / 16, 1'b0);
  endtask

  int base;

  initial begin
    rst_n = 0;
    h = 0; v = 0; pr = 0; pg = 0; pb = 0;
    vld1 = 0; vld2 = 0; vld3 = 0;
    vs1 = 0; vs2 = 0; vs3 = 0;
    repeat (2) @(negedge clk);

    check("rst_wr_en", wen1, 0);
    check("rst_wr_addr", wadr1, 0);
    check("rst_wr_data", wdat1, 0);
    check("rst_done", done1, 0);
    check("rst_drop", drop1, 0);
    check("rst_rd_bank", rdb1, 1);

    rst_n = 1;
    idle(1);

    // default geometry: corner addresses
    pix(3, 0, 0, 1'b0);
    pix(3, 639, 479, 1'b0);
    check("big_first_wen", wen3, 1);
    check("big_first_addr", wadr3, 0);
    idle(1);
    check("big_last_wen", wen3, 1);
    check("big_last_addr", wadr3, 307199);
    check("big_last_data", wdat3, 12'hFF0);
    check("big_last_done", done3, 1);

    // DECIM=2 full frame
    base = wcnt2;
    frame(2, 0, 128);
    idle(3);
    check("d2_writes", wcnt2 - base, 32);
    check("d2_done_cnt", dcnt2, 1);
    check("d2_done_addr", dadr2, 6'h1F);
    check("d2_done_data", ddat2, 12'hE60);
    check("d2_done_with_wr", dwr2, 1);

    // frame A to bank 0
    frame(1, 0, 128);
    idle(3);
    check("a_writes", wcnt1, 128);
    check("a_done_cnt", dcnt1, 1);
    check("a_done_addr", dadr1, 8'h7F);
    check("a_done_data", ddat1, 12'hF70);
    check("a_done_with_wr", dwr1, 1);
    check("a_drop", drop1, 0);

    // swap
    check("b_rd_bank_pre", rdb1, 1);
    vsync(1);
    check("b_rd_bank_post", rdb1, 0);

    // frame C to bank 1
    base = wcnt1;
    pix(1, 0, 0, 1'b0);
    idle(1);
    check("c_first_wen", wen1, 1);
    check("c_first_addr", wadr1, 8'h80);
    frame(1, 1, 128);
    idle(3);
    check("c_writes", wcnt1 - base, 128);
    check("c_done_cnt", dcnt1, 2);
    check("c_done_addr", dadr1, 8'hFF);

    // frame D while pending: dropped
    base = wcnt1;
    frame(1, 0, 128);
    idle(3);
    check("d_writes", wcnt1 - base, 0);
    check("d_drop", drop1, 1);
    check("d_done_cnt", dcnt1, 2);

    vsync(1);
    check("e_rd_bank", rdb1, 1);

    // truncated frame plus out-of-range pixel
    base = wcnt1;
    for (int i = 0; i < 64; i++) begin
      if (i == 40) pix(1, 700, 2, 1'b0);
      pix(1, i % 16, i / 16, 1'b0);
    end
    idle(3);
    check("f_writes", wcnt1 - base, 64);
    check("f_no_done", dcnt1, 2);
    pix(1, 0, 0, 1'b0);
    idle(1);
    check("f_restart_wen", wen1, 1);
    check("f_restart_addr", wadr1, 8'h00);
    check("f_drop", drop1, 2);
    frame(1, 1, 128);
    idle(3);
    check("f_done_cnt", dcnt1, 3);
    check("f_done_addr", dadr1, 8'h7F);

    // vsync coincident with first pixel
    pix(1, 0, 0, 1'b1);
    check("g_rd_bank", rdb1, 0);
    idle(1);
    check("g_wen", wen1, 1);
    check("g_addr", wadr1, 8'h80);
    check("g_drop", drop1, 2);

    // reset mid-frame
    frame(1, 1, 40);
    check("h_pre_wen", wen1, 1);
    #2 rst_n = 0;
    #1;
    check("h_rst_wen", wen1, 0);
    check("h_rst_addr", wadr1, 0);
    check("h_rst_data", wdat1, 0);
    check("h_rst_done", done1, 0);
    check("h_rst_drop", drop1, 0);
    check("h_rst_rd_bank", rdb1, 1);
    @(negedge clk);
    rst_n = 1;
    base = wcnt1;
    pix(1, 5, 0, 1'b0);
    idle(3);
    check("h_no_write", wcnt1 - base, 0);
    pix(1, 0, 0, 1'b0);
    idle(1);
    check("h_new_wen", wen1, 1);
    check("h_new_addr", wadr1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Frame-buffer write controller placed directly downstream of the OV7670 receiver/BRAM-interface stage. Consumes per-pixel coordinates, valid strobe and 4:4:4 RGB, optionally decimates 2:1 in both axes, and writes 12-bit pixels into a ping-pong dual-bank BRAM. Manages bank ownership against the VGA reader via a frame-start pulse, so the display never shows a partially written frame.

## Interface
- H_WIDTH, 640, active pixels per line from the receiver
- V_WIDTH, 480, active lines per frame
- DECIM, 1, decimation factor; legal values 1 or 2
- PXL_WIDTH, 12, stored pixel width ({R,G,B} 4:4:4)
- ADDR_WIDTH, clog2((H_WIDTH/DECIM)*(V_WIDTH/DECIM))+1, BRAM write address width; MSB is the bank bit (20 for the defaults, 18 for DECIM=2)

Ports:
- i_clk  in  1  system clock
- i_n_reset  in  1  asynchronous, active-low reset
- i_h_addr  in  10  pixel column
- i_v_addr  in  10  pixel row
- i_valid  in  1  pixel strobe, one cycle per pixel
- i_pxl_r / i_pxl_g / i_pxl_b  in  4 each  pixel colour
- i_rd_vsync  in  1  one-cycle pulse from the VGA reader at its frame start
- o_wr_en  out  1  BRAM write enable
- o_wr_addr  out  ADDR_WIDTH  {bank, linear address}
- o_wr_data  out  PXL_WIDTH  {r,g,b}
- o_rd_bank  out  1  bank the reader must display
- o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
- o_drop_cnt  out  8  count of dropped/truncated frames, saturating at 255

## Operation
- Accept a pixel when i_valid=1, i_h_addr<H_WIDTH, i_v_addr<V_WIDTH and, for DECIM=2, i_h_addr[0]=0 and i_v_addr[0]=0. All other pixels are ignored.
- Linear address = (v/DECIM)*(H_WIDTH/DECIM) + h/DECIM. The bank bit is wr_bank.
- First pixel is (0,0). Last pixel is (H_WIDTH-DECIM, V_WIDTH-DECIM).
- FSM states: IDLE, WRITE, PEND.
  - IDLE: ignore pixels until an accepted first pixel arrives. Write it, then go to WRITE.
  - WRITE: write every accepted pixel.
    - Accepted last pixel: write it, pulse o_frame_done, go to PEND.
    - Accepted first pixel (truncated frame): restart in the same bank, write it, increment o_drop_cnt, stay in WRITE.
  - PEND: wr_bank holds a complete frame. No writes occur.
    - i_rd_vsync=1: rd_bank<=wr_bank, wr_bank<=~wr_bank. If an accepted first pixel arrives in the same cycle, write it to the new bank and go to WRITE; otherwise go to IDLE.
    - An accepted first pixel without i_rd_vsync: frame dropped, increment o_drop_cnt, stay in PEND.
- i_rd_vsync in IDLE or WRITE has no effect.
- o_drop_cnt saturates at 255.

## Timing
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_frame_done=0, o_drop_cnt=0
  - wr_bank=0, o_rd_bank=1, state IDLE
- Reset mid-frame: all of the above are restored immediately (asynchronously). The next write needs a new first pixel.
- Latency: accepted pixel at cycle N gives o_wr_en=1 with its address and data at cycle N+2. Stage 1 registers inputs and the accept flag; stage 2 registers the product and sum.
- o_frame_done is asserted in the same cycle as o_wr_en for the last pixel.
- Bank swap: o_rd_bank changes in the cycle after i_rd_vsync is sampled in PEND. A write to the new bank is issued no earlier than 2 cycles after the swap.
- Back-to-back accepted pixels every cycle are supported. No stalls, no backpressure.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, WRITE, PEND)
  - clog2 function
  - localparams for line and frame pixel counts and ADDR_WIDTH
- Sub-module fb_addr_gen: the 2-stage coordinate-to-linear-address pipeline, including decimation qualification and pixel data delay. The FSM and bank logic stay in vga_fb_writer.

## Test plan
- Full frame, DECIM=1, pixel at (h,v) with RGB = h[3:0],v[3:0],0 → 307200 writes. Address of (639,479) = 307199 in bank 0. o_frame_done fires once, together with that write.
- PEND then i_rd_vsync → o_rd_bank 1→0 one cycle later. The next frame's (0,0) is written to address {1,0}, i.e. 0x80000.
- Second full frame arrives in PEND with no i_rd_vsync → zero writes, o_drop_cnt=1. A later vsync swaps banks; the following frame writes normally.
- DECIM=2 frame → 76800 writes. (638,478) maps to address 76799. Odd rows and columns produce no o_wr_en.
- Truncated frame (new (0,0) at v=100) → restart at address {bank,0}, o_drop_cnt increments, no o_frame_done. Out-of-range h=700 produces no write.
- i_rd_vsync coincident with (0,0) in PEND → swap and a write of (0,0) to the new bank at N+2. Drop count unchanged. Assert i_n_reset mid-frame → all outputs return to reset values.
